// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Purpose  : Shared constants, types and helpers for the MIPS pipeline
//             hazard control logic.
//  Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

    // E-stage operand mux select encodings
    localparam logic [1:0] FWD_RF = 2'b00;   // value read from the register file
    localparam logic [1:0] FWD_W  = 2'b01;   // result currently in W
    localparam logic [1:0] FWD_M  = 2'b10;   // result currently in M

    // Default mult/div occupancy in cycles after the start edge (legal 1..15)
    localparam int MD_LAT_DEFAULT = 4;

    // Mult/div unit occupancy state
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // Pick the forwarding source for one E-stage operand. M wins over W
    // because it holds the younger write to the same register. Register 0
    // is hard-wired to zero and is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic       regwrite_m,
        input logic [4:0] writereg_m,
        input logic       regwrite_w,
        input logic [4:0] writereg_w,
        input logic [4:0] src
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (regwrite_m && (writereg_m != 5'd0) && (writereg_m == src)) begin
            sel = FWD_M;
        end else if (regwrite_w && (writereg_w != 5'd0) && (writereg_w == src)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_busy_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : md_busy_tracker
//  Purpose  : Tracks occupancy of the multi-cycle mult/div unit. MdBusy is
//             high for exactly MD_LAT cycles after the edge that samples
//             MdStartE in IDLE.
//  Revision : 1.0  initial release
// ============================================================================
module md_busy_tracker
    import mips_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic MdStartE,
    output logic MdBusy
);

    localparam logic [3:0] c_md_lat = 4'(MD_LAT);

    md_state_t  state_q, state_d;
    logic [3:0] md_cnt_q, md_cnt_d;

    // Next-state and countdown; a start request while BUSY is ignored
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            IDLE: begin
                if (MdStartE) begin
                    state_d  = BUSY;
                    md_cnt_d = c_md_lat;
                end
            end
            BUSY: begin
                md_cnt_d = md_cnt_q - 4'd1;
                if (md_cnt_q == 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                md_cnt_d = 4'd0;
            end
        endcase
    end

    // State and counter registers; reset discards any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            md_cnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    assign MdBusy = (state_q == BUSY);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Stall, flush and forwarding control for the 5-stage MIPS
//             pipeline: load-use and mult/div hazards, taken-branch redirect
//             resolved in E, and a saturating stall-cycle counter.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEFAULT,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic [4:0]       WriteRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             BranchE,
    input  logic             ZeroE,
    input  logic             MdStartE,
    input  logic             MdUseD,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             PCSrcE,
    output logic             MdBusy,
    output logic [CNT_W-1:0] StallCount
);

    logic             w_lwstall;
    logic             w_mdstall;
    logic             w_pcsrc;
    logic             w_stall;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // The E-stage destination is never a forwarding source (its result is
    // not ready yet), so these inputs are intentionally not consumed.
    logic w_unused;
    assign w_unused = ^{WriteRegE, RegWriteE};

    md_busy_tracker #(
        .MD_LAT (MD_LAT)
    ) u_md_busy (
        .clk      (clk),
        .reset    (reset),
        .MdStartE (MdStartE),
        .MdBusy   (MdBusy)
    );

    // Raw hazard conditions; a taken branch squashes D, so it overrides stalls
    always_comb begin
        w_lwstall = MemtoRegE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));
        w_mdstall = MdBusy && MdUseD;
        w_pcsrc   = BranchE && ZeroE;
        w_stall   = (w_lwstall || w_mdstall) && !w_pcsrc;
    end

    // Pipeline controls; reset holds the pipe flushed with no redirect
    always_comb begin
        if (reset) begin
            StallF    = 1'b0;
            StallD    = 1'b0;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            PCSrcE    = 1'b0;
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
        end else begin
            StallF    = w_stall;
            StallD    = w_stall;
            FlushD    = w_pcsrc;
            FlushE    = w_lwstall || w_mdstall || w_pcsrc;
            PCSrcE    = w_pcsrc;
            ForwardAE = fwd_sel(RegWriteM, WriteRegM, RegWriteW, WriteRegW, RsE);
            ForwardBE = fwd_sel(RegWriteM, WriteRegM, RegWriteW, WriteRegW, RtE);
        end
    end

    // Saturating count of cycles in which D is held
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (StallD && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Purpose  : Self-checking bench for hazard_ctrl: table of combinational
//             vectors plus hand-written multi-cycle sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int MD_LAT = 4;

    logic             clk;
    logic             reset;
    logic [4:0]       RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic             RegWriteE, RegWriteM, RegWriteW;
    logic             MemtoRegE, BranchE, ZeroE, MdStartE, MdUseD;
    logic             StallF, StallD, FlushD, FlushE, PCSrcE, MdBusy;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [CNT_W-1:0] StallCount;

    int n_total = 0;
    int n_pass  = 0;

    hazard_ctrl #(
        .MD_LAT (MD_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .RsD        (RsD),
        .RtD        (RtD),
        .RsE        (RsE),
        .RtE        (RtE),
        .WriteRegE  (WriteRegE),
        .WriteRegM  (WriteRegM),
        .WriteRegW  (WriteRegW),
        .RegWriteE  (RegWriteE),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .MemtoRegE  (MemtoRegE),
        .BranchE    (BranchE),
        .ZeroE      (ZeroE),
        .MdStartE   (MdStartE),
        .MdUseD     (MdUseD),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .PCSrcE     (PCSrcE),
        .MdBusy     (MdBusy),
        .StallCount (StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starting a mult/div while one is in flight is illegal
    always @(posedge clk) begin
        if (!reset && MdStartE && MdBusy) begin
            n_total = n_total + 1;
            $display("FAIL md_start_while_busy: MdStartE=1 with MdBusy=1 (required no start)");
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total = n_total + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; BranchE = 0; ZeroE = 0; MdStartE = 0; MdUseD = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [4:0] rsd, rtd, rse, rte, wrm, wrw;
        logic       rwm, rww, mtr, br, zr, mdu;
        logic [1:0] fae, fbe;
        logic       sf, sd, fd, fe, pc;
    } vec_t;

    vec_t vecs[12];

    initial begin
        reset = 1'b1;
        clear_inputs();

        // Field order: rsd rtd rse rte wrm wrw | rwm rww mtr br zr mdu | fae fbe | sf sd fd fe pc
        vecs[0]  = '{5'd0, 5'd0, 5'd8, 5'd8, 5'd8, 5'd8, 1, 1, 0, 0, 0, 0, 2'b10, 2'b10, 0, 0, 0, 0, 0};
        vecs[1]  = '{5'd0, 5'd0, 5'd8, 5'd8, 5'd8, 5'd8, 0, 1, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 0, 0, 0};
        vecs[2]  = '{5'd0, 5'd0, 5'd8, 5'd8, 5'd0, 5'd0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0};
        vecs[3]  = '{5'd0, 5'd0, 5'd3, 5'd5, 5'd3, 5'd5, 1, 1, 0, 0, 0, 0, 2'b10, 2'b01, 0, 0, 0, 0, 0};
        vecs[4]  = '{5'd9, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 1, 0};
        vecs[5]  = '{5'd0, 5'd9, 5'd0, 5'd9, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 1, 0};
        vecs[6]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0};
        vecs[7]  = '{5'd9, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0};
        vecs[8]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0, 1, 1, 1};
        vecs[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0};
        vecs[10] = '{5'd9, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 0, 0, 1, 1, 1};
        vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0};

        // ---------------- reset behaviour with hazards present ----------------
        @(negedge clk);
        MemtoRegE = 1; RtE = 9; RsD = 9; RsE = 8;
        RegWriteM = 1; WriteRegM = 8; BranchE = 1; ZeroE = 1;
        #1;
        chk("rst_stallf", 32'(StallF), 32'd0);
        chk("rst_stalld", 32'(StallD), 32'd0);
        chk("rst_flushd", 32'(FlushD), 32'd1);
        chk("rst_flushe", 32'(FlushE), 32'd1);
        chk("rst_pcsrc",  32'(PCSrcE), 32'd0);
        chk("rst_fwda",   32'(ForwardAE), 32'd0);
        @(posedge clk); #1;
        chk("rst_mdbusy", 32'(MdBusy), 32'd0);
        chk("rst_count",  32'(StallCount), 32'd0);
        do_reset();

        // ---------------- combinational vector table ----------------
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            clear_inputs();
            RsD = vecs[i].rsd; RtD = vecs[i].rtd; RsE = vecs[i].rse; RtE = vecs[i].rte;
            WriteRegM = vecs[i].wrm; WriteRegW = vecs[i].wrw;
            RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
            MemtoRegE = vecs[i].mtr; BranchE = vecs[i].br; ZeroE = vecs[i].zr;
            MdUseD = vecs[i].mdu;
            #1;
            chk($sformatf("v%0d_fwda", i),   32'(ForwardAE), 32'(vecs[i].fae));
            chk($sformatf("v%0d_fwdb", i),   32'(ForwardBE), 32'(vecs[i].fbe));
            chk($sformatf("v%0d_stallf", i), 32'(StallF),    32'(vecs[i].sf));
            chk($sformatf("v%0d_stalld", i), 32'(StallD),    32'(vecs[i].sd));
            chk($sformatf("v%0d_flushd", i), 32'(FlushD),    32'(vecs[i].fd));
            chk($sformatf("v%0d_flushe", i), 32'(FlushE),    32'(vecs[i].fe));
            chk($sformatf("v%0d_pcsrc", i),  32'(PCSrcE),    32'(vecs[i].pc));
        end

        // ---------------- load-use counts one stall cycle ----------------
        do_reset();
        @(negedge clk);
        MemtoRegE = 1; RtE = 9; RsD = 9;
        #1;
        chk("lu_count_before", 32'(StallCount), 32'd0);
        @(posedge clk); #1;
        chk("lu_count_after", 32'(StallCount), 32'd1);

        // ---------------- taken branch leaves the counter alone ----------------
        @(negedge clk);
        BranchE = 1; ZeroE = 1;
        @(posedge clk); #1;
        chk("br_count", 32'(StallCount), 32'd1);
        chk("br_stalld", 32'(StallD), 32'd0);

        // ---------------- mult/div latency ----------------
        do_reset();
        @(negedge clk);
        MdStartE = 1; MdUseD = 1;
        #1;
        chk("md_c0_busy", 32'(MdBusy), 32'd0);
        chk("md_c0_stalld", 32'(StallD), 32'd0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            MdStartE = 0;
            #1;
            chk($sformatf("md_c%0d_busy", c),   32'(MdBusy), (c <= 4) ? 32'd1 : 32'd0);
            chk($sformatf("md_c%0d_stalld", c), 32'(StallD), (c <= 4) ? 32'd1 : 32'd0);
        end
        chk("md_count", 32'(StallCount), 32'd4);

        // ---------------- reset in the middle of a mult/div ----------------
        do_reset();
        @(negedge clk);
        MdStartE = 1; MdUseD = 1;
        @(negedge clk);
        MdStartE = 0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mr_count_pre", 32'(StallCount), 32'd1);
        chk("mr_busy_pre", 32'(MdBusy), 32'd1);
        chk("mr_stallf", 32'(StallF), 32'd0);
        chk("mr_stalld", 32'(StallD), 32'd0);
        chk("mr_flushd", 32'(FlushD), 32'd1);
        chk("mr_flushe", 32'(FlushE), 32'd1);
        @(posedge clk); #1;
        chk("mr_busy_post", 32'(MdBusy), 32'd0);
        chk("mr_count_post", 32'(StallCount), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mr_no_stall", 32'(StallD), 32'd0);

        // ---------------- counter saturation ----------------
        do_reset();
        @(negedge clk);
        MemtoRegE = 1; RtE = 9; RtD = 9;
        repeat (20) @(posedge clk);
        #1;
        chk("sat_20", 32'(StallCount), 32'd15);
        @(posedge clk); #1;
        chk("sat_hold", 32'(StallCount), 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
